exe_stage_unit: RTL and testbench

EXE_STAGE_UNIT -- requirements
Module: exe_stage_unit

---
 rtl/exe_stage_unit_pkg.sv | 63 ++++++
 rtl/exe_mul_iter.sv | 51 +++++
 rtl/exe_stage_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_exe_stage_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_unit_pkg.sv
// Shared constants for the execute stage: widths, opcode, shift-type and
// forwarding-select encodings, plus the rotate helper used by the operand shifter.
package exe_stage_unit_pkg;

    localparam int DATA_W    = 32;
    localparam int CMD_W     = 4;
    localparam int DEST_W    = 4;
    localparam int SHOP_W    = 12;
    localparam int SEL_W     = 2;
    localparam int STATUS_W  = 4;
    localparam int MUL_ITERS = 32;

    typedef enum logic [CMD_W-1:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001,
        CMD_MUL = 4'b1111
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    typedef enum logic [SEL_W-1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } status_t;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_e;

    typedef enum logic [1:0] {
        OUT_ALU,
        OUT_BUBBLE,
        OUT_MUL
    } out_sel_e;

    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x,
                                                input logic [4:0]        amt);
        return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: loads operands on start, then performs one
// partial-product step per clock; done holds once all iterations have run.
module exe_mul_iter
    import exe_stage_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam logic [5:0] ITER_LAST = 6'(MUL_ITERS);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [5:0]        iter_cnt;
    logic              active;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            iter_cnt <= '0;
            active   <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            mcand    <= multiplicand;
            mplier   <= multiplier;
            iter_cnt <= '0;
            active   <= 1'b1;
        end else if (active && (iter_cnt != ITER_LAST)) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            iter_cnt <= iter_cnt + 6'd1;
        end
    end

    assign done    = active && (iter_cnt == ITER_LAST);
    assign product = acc;

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: forwarding muxes, operand shifter, ALU, NZCV register and output
// register. Define EXE_STAGE_MUL_EN to build in the iterative multiplier and busy stall.
module exe_stage_unit
    import exe_stage_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                wb_en_in,
    input  logic                mem_r_en_in,
    input  logic                mem_w_en_in,
    input  logic                s_in,
    input  logic                imm,
    input  logic [CMD_W-1:0]    exe_cmd,
    input  logic [DATA_W-1:0]   val_rn,
    input  logic [DATA_W-1:0]   val_rm,
    input  logic [SHOP_W-1:0]   shift_operand,
    input  logic [DEST_W-1:0]   dest_in,
    input  logic [SEL_W-1:0]    sel_src1,
    input  logic [SEL_W-1:0]    sel_src2,
    input  logic [DATA_W-1:0]   fwd_mem,
    input  logic [DATA_W-1:0]   fwd_wb,
    output logic                wb_en_out,
    output logic                mem_r_en_out,
    output logic                mem_w_en_out,
    output logic [DATA_W-1:0]   alu_res_out,
    output logic [DATA_W-1:0]   val_r_m_out,
    output logic [DEST_W-1:0]   dest_out,
    output logic [STATUS_W-1:0] status_out,
    output logic                busy
);

    exe_cmd_e          cmd;
    out_sel_e          out_sel;
    status_t           status_q;
    status_t           alu_flags;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W:0]   sum;
    logic              add_cin;
    logic [4:0]        shamt;

    assign cmd   = exe_cmd_e'(exe_cmd);
    assign shamt = shift_operand[11:7];

    always_comb begin
        case (fwd_sel_e'(sel_src1))
            FWD_MEM: src1 = fwd_mem;
            FWD_WB:  src1 = fwd_wb;
            default: src1 = val_rn;
        endcase
        case (fwd_sel_e'(sel_src2))
            FWD_MEM: src2 = fwd_mem;
            FWD_WB:  src2 = fwd_wb;
            default: src2 = val_rm;
        endcase
    end

    // Memory ops take the raw 12-bit offset; immediates rotate by twice the 4-bit field.
    always_comb begin
        val2 = src2;
        if (imm) begin
            val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
        end else if (mem_r_en_in || mem_w_en_in) begin
            val2 = {20'b0, shift_operand};
        end else begin
            case (shift_e'(shift_operand[6:5]))
                SHIFT_LSL: val2 = src2 << shamt;
                SHIFT_LSR: val2 = src2 >> shamt;
                SHIFT_ASR: val2 = $unsigned($signed(src2) >>> shamt);
                default:   val2 = ror32(src2, shamt);
            endcase
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a value unassigned and infers a latch.
    always_comb begin
        add_b   = val2;
        add_cin = 1'b0;
        case (cmd)
            CMD_ADC: add_cin = status_q.c;
            CMD_SUB: begin
                add_b   = ~val2;
                add_cin = 1'b1;
            end
            CMD_SBC: begin
                add_b   = ~val2;
                add_cin = status_q.c;
            end
            default: ;
        endcase
        sum = {1'b0, src1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

        alu_res     = '0;
        alu_flags.c = status_q.c;
        alu_flags.v = status_q.v;
        case (cmd)
            CMD_MOV, CMD_MUL: alu_res = val2;
            CMD_MVN:          alu_res = ~val2;
            CMD_AND:          alu_res = src1 & val2;
            CMD_ORR:          alu_res = src1 | val2;
            CMD_EOR:          alu_res = src1 ^ val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                alu_res     = sum[DATA_W-1:0];
                alu_flags.c = sum[DATA_W];
                alu_flags.v = (src1[31] == add_b[31]) && (sum[31] != src1[31]);
            end
            default: alu_res = '0;
        endcase
        alu_flags.n = alu_res[31];
        alu_flags.z = (alu_res == '0);
    end

`ifdef EXE_STAGE_MUL_EN
    mul_state_e        mul_state;
    mul_state_e        mul_state_next;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic              mul_wb_en;
    logic              mul_s;
    logic [DEST_W-1:0] mul_dest;

    assign mul_start = (mul_state == MUL_IDLE) && (cmd == CMD_MUL) && !freeze;

    exe_mul_iter u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (mul_start),
        .multiplicand (src1),
        .multiplier   (src2),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_state <= MUL_IDLE;
            mul_wb_en <= 1'b0;
            mul_s     <= 1'b0;
            mul_dest  <= '0;
        end else begin
            mul_state <= mul_state_next;
            if (mul_start) begin
                mul_wb_en <= wb_en_in;
                mul_s     <= s_in;
                mul_dest  <= dest_in;
            end
        end
    end

    // Upstream moves on at the issue edge, so control bits travel with the multiplier.
    always_comb begin
        mul_state_next = mul_state;
        out_sel        = OUT_ALU;
        case (mul_state)
            MUL_IDLE: begin
                if (mul_start) begin
                    mul_state_next = MUL_RUN;
                    out_sel        = OUT_BUBBLE;
                end
            end
            MUL_RUN: begin
                out_sel = OUT_BUBBLE;
                if (mul_done) begin
                    mul_state_next = MUL_DONE;
                end
            end
            MUL_DONE: begin
                out_sel = OUT_MUL;
                if (!freeze) begin
                    mul_state_next = MUL_IDLE;
                end
            end
            default: mul_state_next = MUL_IDLE;
        endcase
    end

    assign busy = (mul_state != MUL_IDLE);
`else
    assign out_sel = OUT_ALU;
    assign busy    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            alu_res_out  <= '0;
            val_r_m_out  <= '0;
            dest_out     <= '0;
            status_q     <= '0;
        end else if (!freeze) begin
            case (out_sel)
                OUT_ALU: begin
                    wb_en_out    <= wb_en_in;
                    mem_r_en_out <= mem_r_en_in;
                    mem_w_en_out <= mem_w_en_in;
                    alu_res_out  <= alu_res;
                    val_r_m_out  <= src2;
                    dest_out     <= dest_in;
                    if (s_in) begin
                        status_q <= alu_flags;
                    end
                end
`ifdef EXE_STAGE_MUL_EN
                OUT_MUL: begin
                    wb_en_out    <= mul_wb_en;
                    mem_r_en_out <= 1'b0;
                    mem_w_en_out <= 1'b0;
                    alu_res_out  <= mul_product;
                    val_r_m_out  <= '0;
                    dest_out     <= mul_dest;
                    if (mul_s) begin
                        status_q <= '{n: mul_product[31], z: (mul_product == '0),
                                      c: status_q.c, v: status_q.v};
                    end
                end
`endif
                default: begin
                    wb_en_out    <= 1'b0;
                    mem_r_en_out <= 1'b0;
                    mem_w_en_out <= 1'b0;
                    alu_res_out  <= '0;
                    val_r_m_out  <= '0;
                    dest_out     <= '0;
                end
            endcase
        end
    end

    assign status_out = status_q;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed bench for exe_stage_unit; multiplier scenarios follow EXE_STAGE_MUL_EN.
module tb_exe_stage_unit;

    localparam logic [3:0] C_MOV = 4'b0001, C_MVN = 4'b1001, C_ADD = 4'b0010,
                           C_ADC = 4'b0011, C_SUB = 4'b0100, C_SBC = 4'b0101,
                           C_AND = 4'b0110, C_ORR = 4'b0111, C_EOR = 4'b1000,
                           C_MUL = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze, wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm;
    logic [3:0]  exe_cmd, dest_in;
    logic [31:0] val_rn, val_rm, fwd_mem, fwd_wb;
    logic [11:0] shift_operand;
    logic [1:0]  sel_src1, sel_src2;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, busy;
    logic [31:0] alu_res_out, val_r_m_out;
    logic [3:0]  dest_out, status_out;

    int total = 0;
    int bad   = 0;

    exe_stage_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .s_in(s_in), .imm(imm), .exe_cmd(exe_cmd),
        .val_rn(val_rn), .val_rm(val_rm), .shift_operand(shift_operand), .dest_in(dest_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_res_out(alu_res_out), .val_r_m_out(val_r_m_out), .dest_out(dest_out),
        .status_out(status_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Flag/logic sequence: each row runs with s_in=1 and the status carried from the row before.
    localparam logic [3:0]  LG_CMD [14] = '{C_ADD, C_AND, C_EOR, C_ORR, C_MVN, C_MOV, C_SUB,
                                            C_SBC, C_ADD, C_SBC, C_SUB, C_ADC, C_SUB, C_ADC};
    localparam logic [31:0] LG_RN  [14] = '{32'h7FFFFFFF, 32'h0000F0F0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'd5,
                                            32'd10, 32'd1, 32'd10, 32'd3, 32'd1, 32'h80000000, 32'hFFFFFFFF};
    localparam logic [31:0] LG_RM  [14] = '{32'd1, 32'h00000FF0, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 32'd5,
                                            32'd3, 32'd1, 32'd3, 32'd5, 32'd1, 32'd1, 32'd0};
    localparam logic [31:0] LG_RES [14] = '{32'h80000000, 32'h000000F0, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0,
                                            32'd7, 32'd2, 32'd6, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF, 32'h0};
    localparam logic [3:0]  LG_ST  [14] = '{4'b1001, 4'b0001, 4'b1001, 4'b0101, 4'b1001, 4'b0101, 4'b0110,
                                            4'b0010, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0011, 4'b0110};

    // Operand-2 shifter rows, all MOV so the result is val2.
    localparam logic [31:0] SH_RM  [10] = '{32'h40000001, 32'h80000000, 32'h80000000, 32'h0000000F, 32'h0,
                                            32'h0, 32'hDEADBEEF, 32'h0, 32'h12345678, 32'h40000000};
    localparam logic [11:0] SH_SO  [10] = '{12'h080, 12'h220, 12'h240, 12'h260, 12'h4FF,
                                            12'h2FF, 12'h000, 12'h0AB, 12'h400, 12'h240};
    localparam logic        SH_IMM [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [31:0] SH_EXP [10] = '{32'h80000002, 32'h08000000, 32'hF8000000, 32'hF0000000, 32'hFF000000,
                                            32'hF000000F, 32'hDEADBEEF, 32'h000000AB, 32'h34567800, 32'h04000000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [11:0] so, input logic im, input logic s, input logic wb,
                         input logic mr, input logic mw, input logic [3:0] dst);
        exe_cmd = cmd; val_rn = rn; val_rm = rm; shift_operand = so; imm = im; s_in = s;
        wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw; dest_in = dst;
        sel_src1 = 2'b00; sel_src2 = 2'b00;
    endtask

    task automatic test_reset();
        freeze = 1'b0; fwd_mem = '0; fwd_wb = '0;
        drive(C_ADD, 32'd1, 32'd2, 12'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7);
        rst = 1'b1;
        step(); step();
        total++; if (alu_res_out !== 32'h0) begin bad++; $display("FAIL reset_alu_res: got %h want 0", alu_res_out); end
        total++; if ({wb_en_out, mem_r_en_out, mem_w_en_out} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {wb_en_out, mem_r_en_out, mem_w_en_out}); end
        total++; if (dest_out !== 4'd0) begin bad++; $display("FAIL reset_dest: got %h want 0", dest_out); end
        total++; if (status_out !== 4'b0000) begin bad++; $display("FAIL reset_status: got %b want 0000", status_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        drive(C_ADD, 32'h7FFFFFFF, 32'h0, 12'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        step();
        total++; if (alu_res_out !== 32'h80000000) begin bad++; $display("FAIL add_ovf_res: got %h want 80000000", alu_res_out); end
        total++; if (status_out !== 4'b1001) begin bad++; $display("FAIL add_ovf_status: got %b want 1001", status_out); end
        total++; if (wb_en_out !== 1'b1 || dest_out !== 4'd3) begin bad++; $display("FAIL add_ovf_ctrl: got wb=%b dest=%h want wb=1 dest=3", wb_en_out, dest_out); end
    endtask

    task automatic test_sub_adc();
        drive(C_SUB, 32'd5, 32'd5, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        step();
        total++; if (alu_res_out !== 32'h0) begin bad++; $display("FAIL sub_res: got %h want 0", alu_res_out); end
        total++; if (status_out !== 4'b0110) begin bad++; $display("FAIL sub_status: got %b want 0110", status_out); end
        drive(C_ADC, 32'd0, 32'd0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        step();
        total++; if (alu_res_out !== 32'd1) begin bad++; $display("FAIL adc_res: got %h want 1", alu_res_out); end
        total++; if (status_out !== 4'b0110) begin bad++; $display("FAIL adc_status_kept: got %b want 0110", status_out); end
    endtask

    task automatic test_alu_flags();
        for (int i = 0; i < 14; i++) begin
            drive(LG_CMD[i], LG_RN[i], LG_RM[i], 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'(i));
            step();
            total++; if (alu_res_out !== LG_RES[i]) begin bad++; $display("FAIL alu_row%0d_res: got %h want %h", i, alu_res_out, LG_RES[i]); end
            total++; if (status_out !== LG_ST[i]) begin bad++; $display("FAIL alu_row%0d_status: got %b want %b", i, status_out, LG_ST[i]); end
        end
    endtask

    task automatic test_shifter();
        for (int i = 0; i < 10; i++) begin
            drive(C_MOV, 32'h0, SH_RM[i], SH_SO[i], SH_IMM[i], 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
            step();
            total++; if (alu_res_out !== SH_EXP[i]) begin bad++; $display("FAIL shift_row%0d: got %h want %h", i, alu_res_out, SH_EXP[i]); end
        end
        drive(C_ADD, 32'h100, 32'h55, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6);
        step();
        total++; if (alu_res_out !== 32'hBBC) begin bad++; $display("FAIL mem_rd_addr: got %h want 00000bbc", alu_res_out); end
        total++; if (mem_r_en_out !== 1'b1 || mem_w_en_out !== 1'b0 || val_r_m_out !== 32'h55) begin bad++; $display("FAIL mem_rd_ctrl: got r=%b w=%b rm=%h want r=1 w=0 rm=55", mem_r_en_out, mem_w_en_out, val_r_m_out); end
        drive(C_ADD, 32'h200, 32'h0, 12'h004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step();
        total++; if (alu_res_out !== 32'h204 || mem_w_en_out !== 1'b1) begin bad++; $display("FAIL mem_wr: got res=%h w=%b want res=204 w=1", alu_res_out, mem_w_en_out); end
    endtask

    task automatic test_forwarding();
        fwd_mem = 32'h1000; fwd_wb = 32'h0234;
        drive(C_ADD, 32'd1, 32'd2, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
        sel_src1 = 2'b01; sel_src2 = 2'b10;
        step();
        total++; if (alu_res_out !== 32'h1234 || val_r_m_out !== 32'h0234) begin bad++; $display("FAIL fwd_mem_wb: got res=%h rm=%h want 1234/234", alu_res_out, val_r_m_out); end
        sel_src1 = 2'b10; sel_src2 = 2'b01;
        step();
        total++; if (alu_res_out !== 32'h1234 || val_r_m_out !== 32'h1000) begin bad++; $display("FAIL fwd_wb_mem: got res=%h rm=%h want 1234/1000", alu_res_out, val_r_m_out); end
        sel_src1 = 2'b00; sel_src2 = 2'b00;
        step();
        total++; if (alu_res_out !== 32'd3 || val_r_m_out !== 32'd2) begin bad++; $display("FAIL fwd_reg: got res=%h rm=%h want 3/2", alu_res_out, val_r_m_out); end
    endtask

    task automatic test_freeze();
        drive(C_ADD, 32'd1, 32'd1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
        step();
        total++; if (alu_res_out !== 32'd2 || status_out !== 4'b0000) begin bad++; $display("FAIL frz_pre: got res=%h st=%b want 2/0000", alu_res_out, status_out); end
        freeze = 1'b1;
        drive(C_ADD, 32'h7FFFFFFF, 32'd1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (alu_res_out !== 32'd2 || dest_out !== 4'd1) begin bad++; $display("FAIL frz_hold%0d_out: got res=%h dest=%h want 2/1", i, alu_res_out, dest_out); end
            total++; if (status_out !== 4'b0000) begin bad++; $display("FAIL frz_hold%0d_status: got %b want 0000", i, status_out); end
        end
        freeze = 1'b0;
        step();
        total++; if (alu_res_out !== 32'h80000000 || dest_out !== 4'd5) begin bad++; $display("FAIL frz_release_out: got res=%h dest=%h want 80000000/5", alu_res_out, dest_out); end
        total++; if (status_out !== 4'b1001) begin bad++; $display("FAIL frz_release_status: got %b want 1001", status_out); end
        drive(C_MOV, 32'h0, 32'h0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        total++; if (alu_res_out !== 32'h0 || status_out !== 4'b1001) begin bad++; $display("FAIL frz_after: got res=%h st=%b want 0/1001", alu_res_out, status_out); end
    endtask

`ifdef EXE_STAGE_MUL_EN
    task automatic test_mul();
        int  busy_cycles;
        logic saw_wb;
        drive(C_MUL, 32'd7, 32'd6, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
        step();
        drive(C_ADD, 32'd1, 32'd2, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        busy_cycles = 0;
        saw_wb      = 1'b0;
        while (busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            if (wb_en_out !== 1'b0) saw_wb = 1'b1;
            step();
        end
        total++; if (busy_cycles != 34) begin bad++; $display("FAIL mul_busy_len: got %0d want 34", busy_cycles); end
        total++; if (saw_wb !== 1'b0) begin bad++; $display("FAIL mul_bubbles: got wb_en=1 during busy want 0"); end
        total++; if (alu_res_out !== 32'd42 || wb_en_out !== 1'b1 || dest_out !== 4'd9) begin bad++; $display("FAIL mul_result: got res=%h wb=%b dest=%h want 2a/1/9", alu_res_out, wb_en_out, dest_out); end
        total++; if (status_out[3:2] !== 2'b00) begin bad++; $display("FAIL mul_nz: got %b want 00", status_out[3:2]); end
        step();
        total++; if (alu_res_out !== 32'd3 || busy !== 1'b0) begin bad++; $display("FAIL mul_next_add: got res=%h busy=%b want 3/0", alu_res_out, busy); end
    endtask
`else
    task automatic test_mul();
        drive(C_MUL, 32'd7, 32'd6, 12'h005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nomul_busy_issue: got %b want 0", busy); end
        step();
        total++; if (alu_res_out !== 32'd5 || wb_en_out !== 1'b1 || dest_out !== 4'd9) begin bad++; $display("FAIL nomul_imm: got res=%h wb=%b dest=%h want 5/1/9", alu_res_out, wb_en_out, dest_out); end
        total++; if (status_out[3:2] !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL nomul_flags: got nz=%b busy=%b want 00/0", status_out[3:2], busy); end
        drive(C_MUL, 32'd7, 32'd6, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
        step();
        total++; if (alu_res_out !== 32'd6) begin bad++; $display("FAIL nomul_reg: got %h want 6", alu_res_out); end
    endtask
`endif

    task automatic test_reset_mid();
`ifdef EXE_STAGE_MUL_EN
        drive(C_MUL, 32'd7, 32'd6, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
        step();
        drive(C_ADD, 32'd4, 32'd5, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        repeat (10) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
`else
        drive(C_ADD, 32'd1, 32'd1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
        step();
        drive(C_ADD, 32'd4, 32'd5, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
`endif
        #1 rst = 1'b1;
        #1;
        total++; if (alu_res_out !== 32'h0 || wb_en_out !== 1'b0 || dest_out !== 4'd0) begin bad++; $display("FAIL rstmid_out: got res=%h wb=%b dest=%h want 0/0/0", alu_res_out, wb_en_out, dest_out); end
        total++; if (status_out !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_state: got st=%b busy=%b want 0000/0", status_out, busy); end
        #1 rst = 1'b0;
        step();
        total++; if (alu_res_out !== 32'd9 || wb_en_out !== 1'b1 || dest_out !== 4'd4) begin bad++; $display("FAIL rstmid_add: got res=%h wb=%b dest=%h want 9/1/4", alu_res_out, wb_en_out, dest_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_adc();
        test_alu_flags();
        test_shifter();
        test_forwarding();
        test_freeze();
        test_mul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
